// File: rtl/ahb_spi_master.sv
// AHB-Lite zero-wait-state SPI master (CPOL=1, CPHA=1, 8-bit, MSB first)
// with CTRL/SS/DATA/STATUS registers and a level transfer-complete interrupt.
module ahb_spi_master #(
   parameter int         NUM_SS    = 2,
   parameter logic [7:0] DIV_RESET = 8'd3
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              HSEL,
   input  logic              HREADY,
   input  logic [31:0]       HADDR,
   input  logic [1:0]        HTRANS,
   input  logic              HWRITE,
   input  logic [2:0]        HSIZE,
   input  logic [31:0]       HWDATA,
   output logic [31:0]       HRDATA,
   output logic              HREADYOUT,
   input  logic              SPI_MISO_i,
   output logic              SPI_MOSI_o,
   output logic              SPI_CLK_o,
   output logic [NUM_SS-1:0] SPI_SS_o,
   output logic              spi_irq_o
);

   typedef enum logic [1:0] {IDLE = 2'd0, LOW = 2'd1, HIGH = 2'd2} state_t;

   state_t state_q, state_d;

   logic              ap_en;
   logic              dp_valid;
   logic              dp_write;
   logic [1:0]        dp_addr;
   logic              wr_ctrl, wr_ss, wr_data, wr_stat, rd_data;

   logic              en, irqen;
   logic [7:0]        div;
   logic [NUM_SS-1:0] ss;
   logic              busy, done, ovr;
   logic [7:0]        rxbyte;
   logic              mosi;
   logic [3:0]        bit_cnt;

   logic [7:0]        tx_shift, rx_shift;
   logic [7:0]        ph_cnt, div_lat;

   logic              start, abort, phase_end, rise, refall, finish;
   logic              unused;

   assign unused = ^{HSIZE, HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:16]};

   assign ap_en   = HSEL & HREADY & HTRANS[1];
   assign wr_ctrl = dp_valid & dp_write & (dp_addr == 2'd0);
   assign wr_ss   = dp_valid & dp_write & (dp_addr == 2'd1);
   assign wr_data = dp_valid & dp_write & (dp_addr == 2'd2);
   assign wr_stat = dp_valid & dp_write & (dp_addr == 2'd3);
   assign rd_data = dp_valid & ~dp_write & (dp_addr == 2'd2);

   assign busy      = (state_q != IDLE);
   assign start     = wr_data & en & ~busy;
   // Clearing EN aborts in the cycle after the CTRL data phase, like a start.
   assign abort     = busy & (~en | (wr_ctrl & ~HWDATA[0]));
   assign phase_end = (ph_cnt == div_lat);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = LOW;
         LOW:     if (phase_end) state_d = HIGH;
         HIGH:    if (phase_end) state_d = (bit_cnt == 4'd8) ? IDLE : LOW;
         default: state_d = IDLE;
      endcase
      if (abort) state_d = IDLE;
   end

   assign rise   = (state_q == LOW) & (state_d == HIGH);
   assign refall = (state_q == HIGH) & (state_d == LOW);
   assign finish = (state_q == HIGH) & (state_d == IDLE) & ~abort;

   // Shift/phase datapath: DIV is sampled at each phase boundary.
   always_ff @(posedge HCLK) begin
      if (state_d != state_q) begin
         ph_cnt  <= 8'd0;
         div_lat <= div;
      end else begin
         ph_cnt  <= ph_cnt + 8'd1;
      end
      if (start)
         tx_shift <= HWDATA[7:0];
      else if (rise)
         tx_shift <= {tx_shift[6:0], 1'b0};
      if (rise)
         rx_shift <= {rx_shift[6:0], SPI_MISO_i};
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         dp_valid <= 1'b0;
         dp_write <= 1'b0;
         dp_addr  <= 2'd0;
         state_q  <= IDLE;
         en       <= 1'b0;
         irqen    <= 1'b0;
         div      <= DIV_RESET;
         ss       <= '1;
         done     <= 1'b0;
         ovr      <= 1'b0;
         rxbyte   <= 8'd0;
         mosi     <= 1'b1;
         bit_cnt  <= 4'd0;
      end else begin
         dp_valid <= ap_en;
         if (ap_en) begin
            dp_addr  <= HADDR[3:2];
            dp_write <= HWRITE;
         end
         state_q <= state_d;
         if (wr_ctrl) begin
            en    <= HWDATA[0];
            irqen <= HWDATA[1];
            div   <= HWDATA[15:8];
         end
         if (wr_ss)
            ss <= HWDATA[NUM_SS-1:0];
         if (start)
            bit_cnt <= 4'd0;
         else if (rise)
            bit_cnt <= bit_cnt + 4'd1;
         // MOSI is registered so it only moves on SCK falling edges.
         if (start)
            mosi <= HWDATA[7];
         else if (state_d == IDLE)
            mosi <= 1'b1;
         else if (refall)
            mosi <= tx_shift[7];
         if (finish)
            done <= 1'b1;
         else if (rd_data)
            done <= 1'b0;
         if (wr_data & busy)
            ovr <= 1'b1;
         else if (wr_stat & HWDATA[2])
            ovr <= 1'b0;
         if (finish)
            rxbyte <= rx_shift;
      end
   end

   always_comb begin
      HRDATA = 32'd0;
      if (dp_valid & ~dp_write) begin
         case (dp_addr)
            2'd0:    HRDATA = {16'd0, div, 6'd0, irqen, en};
            2'd1:    HRDATA = 32'(ss);
            2'd2:    HRDATA = {24'd0, rxbyte};
            default: HRDATA = {29'd0, ovr, done, busy};
         endcase
      end
   end

   assign HREADYOUT  = 1'b1;
   assign SPI_CLK_o  = (state_q != LOW);
   assign SPI_MOSI_o = mosi;
   assign SPI_SS_o   = ss;
   assign spi_irq_o  = done & irqen;

endmodule
